// File: rtl/param_stream_fifo_if.sv
// Stream FIFO bus: requests and write data in, head word and status out.
// The master side drives requests; the FIFO itself takes the slave side.
interface param_stream_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    // Requests toward the FIFO
    logic             i_Flush;
    logic [WIDTH-1:0] i_Data;
    logic             i_Append_Now;
    logic             i_Shift_Now;
    logic             i_Clear_Errors;

    // Status and head word from the FIFO
    logic [WIDTH-1:0] o_Data;
    logic             o_Empty;
    logic             o_Full;
    logic             o_Almost_Full;
    logic [CW-1:0]    o_Count;
    logic [CW-1:0]    o_Free_Space;
    logic             o_Overflow;
    logic             o_Underflow;

    modport master (
        output i_Flush, i_Data, i_Append_Now, i_Shift_Now, i_Clear_Errors,
        input  o_Data, o_Empty, o_Full, o_Almost_Full, o_Count, o_Free_Space,
               o_Overflow, o_Underflow
    );

    modport slave (
        input  i_Flush, i_Data, i_Append_Now, i_Shift_Now, i_Clear_Errors,
        output o_Data, o_Empty, o_Full, o_Almost_Full, o_Count, o_Free_Space,
               o_Overflow, o_Underflow
    );
endinterface

// File: rtl/param_stream_fifo.sv
// First-word-fall-through FIFO with arbitrary depth, occupancy/free-space
// outputs, almost-full flag, synchronous flush and sticky error flags.
// Every output is derived from registered state only.
module param_stream_fifo #(
    parameter int WIDTH             = 8,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = 6
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    param_stream_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST_C   = CW'(ALMOST_FULL_LEVEL);
    localparam logic [PW-1:0] LAST_PTR_C = PW'(DEPTH - 1);

    // Storage is deliberately not reset; contents are only meaningful
    // between the read and write pointers.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic is_empty;
    logic is_full;
    logic append_ok;
    logic shift_ok;
    logic overflow_evt;
    logic underflow_evt;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR_C) ? '0 : p + 1'b1;
    endfunction

    // Decide what this cycle's requests do, based on pre-edge occupancy.
    always_comb begin
        is_empty = (count_reg == '0);
        is_full  = (count_reg == DEPTH_C);

        // A shift frees the slot a same-cycle append needs when full.
        shift_ok  = bus.i_Shift_Now  && !is_empty && !bus.i_Flush;
        append_ok = bus.i_Append_Now && !bus.i_Flush &&
                    (!is_full || bus.i_Shift_Now);

        // Flush suppresses error reporting for that cycle's requests.
        overflow_evt  = bus.i_Append_Now && !bus.i_Flush &&
                        is_full && !bus.i_Shift_Now;
        underflow_evt = bus.i_Shift_Now && !bus.i_Flush && is_empty;
    end

    // Next pointers, occupancy and sticky flags.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (bus.i_Flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (append_ok) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (shift_ok) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            case ({append_ok, shift_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end

        // A new error event in the same cycle outranks the clear.
        if (bus.i_Clear_Errors) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end
        if (overflow_evt) begin
            overflow_next = 1'b1;
        end
        if (underflow_evt) begin
            underflow_next = 1'b1;
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Write accepted words into storage.
    always_ff @(posedge i_Clk) begin
        if (append_ok) begin
            mem[wr_ptr_reg] <= bus.i_Data;
        end
    end

    // Head word falls through; forced to zero when nothing is stored.
    assign bus.o_Data        = is_empty ? '0 : mem[rd_ptr_reg];
    assign bus.o_Empty       = is_empty;
    assign bus.o_Full        = is_full;
    assign bus.o_Almost_Full = (count_reg >= ALMOST_C);
    assign bus.o_Count       = count_reg;
    assign bus.o_Free_Space  = DEPTH_C - count_reg;
    assign bus.o_Overflow    = overflow_reg;
    assign bus.o_Underflow   = underflow_reg;

endmodule
